uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 151 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start, eight data bits (LSB first) and
// stop through a select code that drives an external TX bit mux.
// Each bit lasts CLKS_PER_BIT clocks. The line idles on the stop/end bit.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic [3:0] sel,
  output logic [7:0] data_lat,
  output logic       start_bit,
  output logic       end_bit,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [3:0]    SEL_START = 4'b0000;
  localparam logic [3:0]    SEL_STOP  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit_idx;
  logic [3:0]    r_sel;
  logic [7:0]    r_data_lat;
  logic          r_busy;
  logic          r_tx_done;

  state_t        w_state_next;
  logic [CW-1:0] w_baud_next;
  logic [2:0]    w_bit_idx_next;
  logic [3:0]    w_sel_next;
  logic [7:0]    w_data_lat_next;
  logic          w_busy_next;
  logic          w_tx_done_next;
  logic          w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

  // State, counters and all outputs are registered; reset aborts any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_sel      <= SEL_STOP;
      r_data_lat <= '0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit_idx  <= w_bit_idx_next;
      r_sel      <= w_sel_next;
      r_data_lat <= w_data_lat_next;
      r_busy     <= w_busy_next;
      r_tx_done  <= w_tx_done_next;
    end
  end

  // Next-state and next-output logic; the done pulse defaults low every cycle.
  always_comb begin
    w_state_next    = r_state;
    w_baud_next     = r_baud;
    w_bit_idx_next  = r_bit_idx;
    w_sel_next      = r_sel;
    w_data_lat_next = r_data_lat;
    w_busy_next     = r_busy;
    w_tx_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_sel_next     = SEL_STOP;
        w_busy_next    = 1'b0;
        w_baud_next    = '0;
        w_bit_idx_next = '0;
        // Also taken in the tx_done cycle, which gives back-to-back frames.
        if (tx_start) begin
          w_state_next    = S_START;
          w_sel_next      = SEL_START;
          w_busy_next     = 1'b1;
          w_data_lat_next = tx_data;
        end
      end

      S_START: begin
        if (w_baud_end) begin
          w_state_next   = S_DATA;
          w_baud_next    = '0;
          w_bit_idx_next = '0;
          w_sel_next     = 4'b0001;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
            w_sel_next   = SEL_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            // Select for the upcoming bit is (next index + 1).
            w_sel_next     = {1'b0, r_bit_idx} + 4'd2;
          end
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end

      S_STOP: begin
        if (w_baud_end) begin
          w_state_next   = S_IDLE;
          w_baud_next    = '0;
          w_busy_next    = 1'b0;
          w_tx_done_next = 1'b1;
          w_sel_next     = SEL_STOP;
        end else begin
          w_baud_next = r_baud + BAUD_ONE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_sel_next   = SEL_STOP;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  assign sel       = r_sel;
  assign data_lat  = r_data_lat;
  assign busy      = r_busy;
  assign tx_done   = r_tx_done;
  assign start_bit = 1'b0;
  assign end_bit   = 1'b1;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one instance at 4 clocks/bit, one at 2.
// The TX line is rebuilt through a reference mux from sel/data_lat/start/end.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, b_start;
  logic [7:0] a_data, b_data;
  logic [3:0] a_sel, b_sel;
  logic [7:0] a_lat, b_lat;
  logic       a_sb, a_eb, b_sb, b_eb;
  logic       a_busy, b_busy, a_done, b_done;
  logic       a_tx, b_tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, t1;
  logic [9:0] seq;

  uart_tx_ctrl #(.CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .tx_start(a_start), .tx_data(a_data),
    .sel(a_sel), .data_lat(a_lat), .start_bit(a_sb), .end_bit(a_eb),
    .busy(a_busy), .tx_done(a_done)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2)) dut_b (
    .clk(clk), .rst(rst), .tx_start(b_start), .tx_data(b_data),
    .sel(b_sel), .data_lat(b_lat), .start_bit(b_sb), .end_bit(b_eb),
    .busy(b_busy), .tx_done(b_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference TX bit mux driven by the controller outputs.
  function automatic logic ref_tx(input logic [3:0] s, input logic [7:0] d,
                                  input logic sb, input logic eb);
    if (s == 4'd0) return sb;
    if (s == 4'd9) return eb;
    if (s >= 4'd1 && s <= 4'd8) return d[s - 4'd1];
    return 1'bx;
  endfunction

  always_comb a_tx = ref_tx(a_sel, a_lat, a_sb, a_eb);
  always_comb b_tx = ref_tx(b_sel, b_lat, b_sb, b_eb);

  // Expected UART line for bit slot k of a frame carrying d.
  function automatic logic frame_bit(input int k, input logic [7:0] d);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return d[k-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge showing the first START cycle; returns at the
  // negedge of the tx_done cycle after checking it.
  task automatic run_frame(input logic [7:0] d, input bit noisy, input logic hold_start,
                           input logic [7:0] next_data, output logic [9:0] s);
    s = '0;
    for (int c = 0; c < 40; c++) begin
      chk("frame_sel", 32'(a_sel), 32'(c / 4));
      chk("frame_sel_range", 32'(a_sel <= 4'd9), 32'd1);
      chk("frame_busy", 32'(a_busy), 32'd1);
      chk("frame_done", 32'(a_done), 32'd0);
      chk("frame_tx", 32'(a_tx), 32'(frame_bit(c / 4, d)));
      chk("frame_lat", 32'(a_lat), 32'(d));
      if (c % 4 == 0) s = {s[8:0], a_tx};
      if (noisy && c >= 5 && c <= 30) begin
        a_start = c[0];
        a_data  = 8'h3C;
      end else begin
        a_start = hold_start;
        a_data  = next_data;
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'(a_done), 32'd1);
    chk("done_busy", 32'(a_busy), 32'd0);
    chk("done_sel", 32'(a_sel), 32'd9);
    chk("done_tx", 32'(a_tx), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_data = 8'h00;
    b_start = 1'b0; b_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(a_sel), 32'd9);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_lat", 32'(a_lat), 32'h00);
    chk("rst_b_sel", 32'(b_sel), 32'd9);
    chk("rst_b_busy", 32'(b_busy), 32'd0);

    // Single A5 frame, requested on the first edge after reset release.
    rst = 1'b0; a_start = 1'b1; a_data = 8'hA5;
    @(negedge clk);
    run_frame(8'hA5, 1'b0, 1'b0, 8'h00, seq);
    chk("a5_seq", 32'(seq), 32'(10'b0101001011));
    @(negedge clk);
    chk("a5_after_done", 32'(a_done), 32'd0);
    chk("a5_after_busy", 32'(a_busy), 32'd0);
    chk("a5_after_sel", 32'(a_sel), 32'd9);
    $display("frame A5 single: seq=%b", seq);

    // Back-to-back 00 then FF with tx_start held high.
    a_start = 1'b1; a_data = 8'h00;
    @(negedge clk);
    t0 = cyc;
    run_frame(8'h00, 1'b0, 1'b1, 8'hFF, seq);
    @(negedge clk);
    t1 = cyc;
    chk("b2b_spacing", 32'(t1 - t0), 32'd41);
    chk("b2b_second_sel", 32'(a_sel), 32'd0);
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, seq);
    chk("ff_seq", 32'(seq), 32'(10'b0111111111));
    @(negedge clk);
    chk("ff_after_busy", 32'(a_busy), 32'd0);
    $display("frames 00/FF back-to-back: spacing=%0d", t1 - t0);

    // tx_start pulses and tx_data=3C during a 55 frame must be ignored.
    a_start = 1'b1; a_data = 8'h55;
    @(negedge clk);
    run_frame(8'h55, 1'b1, 1'b0, 8'h55, seq);
    chk("55_seq", 32'(seq), 32'(10'b0101010101));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_extra_busy", 32'(a_busy), 32'd0);
      chk("no_extra_done", 32'(a_done), 32'd0);
      chk("no_extra_sel", 32'(a_sel), 32'd9);
    end
    $display("frame 55 with noise: seq=%b", seq);

    // Asynchronous reset during data bit 3 aborts the frame.
    a_start = 1'b1; a_data = 8'hC3;
    @(negedge clk);
    a_start = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_sel", 32'(a_sel), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", 32'(a_sel), 32'd9);
    chk("async_rst_busy", 32'(a_busy), 32'd0);
    chk("async_rst_done", 32'(a_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(a_done), 32'd0);
      chk("post_rst_busy", 32'(a_busy), 32'd0);
    end
    a_start = 1'b1; a_data = 8'h81;
    @(negedge clk);
    run_frame(8'h81, 1'b0, 1'b0, 8'h00, seq);
    chk("81_seq", 32'(seq), 32'(10'b0100000011));
    $display("mid-frame reset then frame 81: seq=%b", seq);

    // Two clocks per bit: 20-cycle frame, done on the next cycle.
    b_start = 1'b1; b_data = 8'h96;
    @(negedge clk);
    b_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("b_sel", 32'(b_sel), 32'(c / 2));
      chk("b_busy", 32'(b_busy), 32'd1);
      chk("b_done", 32'(b_done), 32'd0);
      chk("b_tx", 32'(b_tx), 32'(frame_bit(c / 2, 8'h96)));
      @(negedge clk);
    end
    chk("b_done_pulse", 32'(b_done), 32'd1);
    chk("b_done_busy", 32'(b_busy), 32'd0);
    @(negedge clk);
    chk("b_done_clear", 32'(b_done), 32'd0);
    $display("frame 96 at 2 clocks/bit complete");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
